// File: rtl/ctrl_seq.sv
// Multicycle control sequencer for the Stage-3 ALU datapath: walks fetch/decode/
// execute/memory/writeback and decodes the 22-bit control word from state and latched fields.
module ctrl_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  fn,
    input  logic        alu_zero,
    input  logic        ovfl,
    input  logic        mem_ready,
    output logic [21:0] ctrl_out,
    output logic [3:0]  state_dbg,
    output logic        illegal,
    output logic        ovfl_exc,
    output logic        instr_done
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        JUMP_REG = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;

    state_t      r_state;
    logic [5:0]  r_op;
    logic [5:0]  r_fn;
    logic        r_ovfl;

    state_t      w_next;
    logic        w_illegal;
    logic        w_done;
    logic        w_pcwrite, w_instwrite, w_memread, w_memwrite, w_iord, w_zwrite, w_regwrite;
    logic [1:0]  w_pcsrc, w_regdst, w_reginsrc, w_alusrcx, w_alusrcy, w_logicfn, w_fntype;
    logic [21:0] w_ctrl;

    always_comb begin
        w_next      = r_state;
        w_illegal   = 1'b0;
        w_done      = 1'b0;
        w_pcwrite   = 1'b0;
        w_pcsrc     = 2'b00;
        w_instwrite = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_iord      = 1'b0;
        w_zwrite    = 1'b0;
        w_regwrite  = 1'b0;
        w_regdst    = 2'b00;
        w_reginsrc  = 2'b00;
        w_alusrcx   = 2'b00;
        w_alusrcy   = 2'b00;
        w_logicfn   = 2'b00;
        w_fntype    = 2'b00;

        case (r_state)
            FETCH: begin
                w_memread = 1'b1;
                if (mem_ready) begin
                    w_pcwrite   = 1'b1;
                    w_instwrite = 1'b1;
                    w_next      = DECODE;
                end
            end
            DECODE: begin
                // Speculative branch target into Z; dispatch uses the live op/fn.
                w_alusrcy = 2'b11;
                w_zwrite  = 1'b1;
                w_next    = FETCH;
                case (op)
                    OP_RTYPE: begin
                        case (fn)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
                            FN_SLL, FN_SRL, FN_SRA: w_next = EXEC_R;
                            FN_JR:                  w_next = JUMP_REG;
                            default:                w_illegal = 1'b1;
                        endcase
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: w_next = EXEC_I;
                    OP_LW, OP_SW:                      w_next = MEM_ADDR;
                    OP_BEQ, OP_BNE:                    w_next = BRANCH;
                    OP_J, OP_JAL:                      w_next = JUMP;
                    default:                           w_illegal = 1'b1;
                endcase
            end
            EXEC_R: begin
                w_alusrcx = 2'b01;
                w_alusrcy = 2'b01;
                w_zwrite  = 1'b1;
                w_next    = WB_ALU;
                case (r_fn)
                    FN_SUB: w_logicfn = 2'b01;
                    FN_AND: w_fntype  = 2'b01;
                    FN_OR:  begin w_logicfn = 2'b01; w_fntype = 2'b01; end
                    FN_XOR: begin w_logicfn = 2'b10; w_fntype = 2'b01; end
                    FN_NOR: begin w_logicfn = 2'b11; w_fntype = 2'b01; end
                    FN_SLL: begin w_logicfn = 2'b10; w_fntype = 2'b10; w_alusrcy = 2'b10; end
                    FN_SRL: begin w_logicfn = 2'b01; w_fntype = 2'b10; w_alusrcy = 2'b10; end
                    FN_SRA: begin w_logicfn = 2'b11; w_fntype = 2'b10; w_alusrcy = 2'b10; end
                    default: ;
                endcase
            end
            EXEC_I: begin
                w_alusrcx = 2'b01;
                w_alusrcy = 2'b10;
                w_zwrite  = 1'b1;
                w_next    = WB_ALU;
                case (r_op)
                    OP_ANDI: w_fntype = 2'b01;
                    OP_ORI:  begin w_logicfn = 2'b01; w_fntype = 2'b01; end
                    OP_XORI: begin w_logicfn = 2'b10; w_fntype = 2'b01; end
                    default: ;
                endcase
            end
            WB_ALU: begin
                w_regwrite = !r_ovfl;
                w_regdst   = (r_op == OP_RTYPE) ? 2'b01 : 2'b00;
                w_done     = 1'b1;
                w_next     = FETCH;
            end
            MEM_ADDR: begin
                w_alusrcx = 2'b01;
                w_alusrcy = 2'b10;
                w_zwrite  = 1'b1;
                w_next    = (r_op == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                if (mem_ready) w_next = WB_MEM;
            end
            MEM_WR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
                if (mem_ready) begin
                    w_done = 1'b1;
                    w_next = FETCH;
                end
            end
            WB_MEM: begin
                w_regwrite = 1'b1;
                w_reginsrc = 2'b01;
                w_done     = 1'b1;
                w_next     = FETCH;
            end
            BRANCH: begin
                w_alusrcx = 2'b01;
                w_alusrcy = 2'b01;
                w_logicfn = 2'b01;
                w_pcsrc   = 2'b01;
                w_pcwrite = (r_op == OP_BNE) ? !alu_zero : alu_zero;
                w_done    = 1'b1;
                w_next    = FETCH;
            end
            JUMP: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b10;
                if (r_op == OP_JAL) begin
                    w_regwrite = 1'b1;
                    w_regdst   = 2'b10;
                    w_reginsrc = 2'b10;
                end
                w_done = 1'b1;
                w_next = FETCH;
            end
            JUMP_REG: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b11;
                w_done    = 1'b1;
                w_next    = FETCH;
            end
            default: w_next = FETCH;
        endcase

        w_ctrl = {w_pcwrite, w_pcsrc, w_instwrite, w_memread, w_memwrite, w_iord,
                  w_zwrite, w_regwrite, w_regdst, w_reginsrc, 1'b0,
                  w_alusrcx, w_alusrcy, w_logicfn, w_fntype};
    end

    // Outputs are forced quiet for as long as reset is held, not just at the edge.
    assign ctrl_out   = reset ? w_ctrl : 22'd0;
    assign illegal    = reset & w_illegal;
    assign ovfl_exc   = reset & (r_state == WB_ALU) & r_ovfl;
    assign instr_done = reset & w_done;
    assign state_dbg  = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_op    <= 6'd0;
            r_fn    <= 6'd0;
            r_ovfl  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op <= op;
                r_fn <= fn;
            end
            if (w_next == FETCH)
                r_ovfl <= 1'b0;
            else if (r_state == EXEC_R)
                r_ovfl <= ovfl & ((r_fn == FN_ADD) | (r_fn == FN_SUB));
            else if (r_state == EXEC_I)
                r_ovfl <= ovfl & (r_op == OP_ADDI);
        end
    end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: each step sets inputs for the current state and checks
// the combinational control word, state and flags against hand-computed values.
module tb_ctrl_seq;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        alu_zero;
    logic        ovfl;
    logic        mem_ready;
    logic [21:0] ctrl_out;
    logic [3:0]  state_dbg;
    logic        illegal;
    logic        ovfl_exc;
    logic        instr_done;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_seq dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .fn         (fn),
        .alu_zero   (alu_zero),
        .ovfl       (ovfl),
        .mem_ready  (mem_ready),
        .ctrl_out   (ctrl_out),
        .state_dbg  (state_dbg),
        .illegal    (illegal),
        .ovfl_exc   (ovfl_exc),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the full observable output set in the current cycle.
    task automatic chk_all(input string tag, input logic [21:0] e_ctrl, input logic [3:0] e_st,
                           input logic e_ill, input logic e_ovx, input logic e_done);
        #1;
        chk({tag, ".ctrl"},  {10'd0, ctrl_out},   {10'd0, e_ctrl});
        chk({tag, ".state"}, {28'd0, state_dbg},  {28'd0, e_st});
        chk({tag, ".illegal"}, {31'd0, illegal},  {31'd0, e_ill});
        chk({tag, ".ovfl_exc"}, {31'd0, ovfl_exc}, {31'd0, e_ovx});
        chk({tag, ".done"},  {31'd0, instr_done}, {31'd0, e_done});
    endtask

    // From FETCH with mem_ready=1: advance into DECODE with the given op/fn.
    task automatic fetch_decode(input string tag, input logic [5:0] o, input logic [5:0] f);
        mem_ready = 1'b1;
        chk_all({tag, ".fetch"}, 22'h260000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        op = o;
        fn = f;
        chk_all({tag, ".decode"}, 22'h004030, 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b0; op = 6'd0; fn = 6'd0; alu_zero = 1'b0; ovfl = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_hold", 22'h000000, 4'd0, 1'b0, 1'b0, 1'b0);

        reset = 1'b1;
        chk_all("fetch_wait", 22'h020000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("fetch_wait2", 22'h020000, 4'd0, 1'b0, 1'b0, 1'b0);

        // add, no overflow
        fetch_decode("add", 6'b000000, 6'b100000);
        chk_all("add.exec", 22'h004050, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("add.wb", 22'h002800, 4'd4, 1'b0, 1'b0, 1'b1);
        tick();

        // add with overflow: writeback suppressed
        fetch_decode("addov", 6'b000000, 6'b100000);
        ovfl = 1'b1;
        chk_all("addov.exec", 22'h004050, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        ovfl = 1'b0;
        chk_all("addov.wb", 22'h000800, 4'd4, 1'b0, 1'b1, 1'b1);
        tick();

        // sub: overflow on a logic op must not be registered
        fetch_decode("sub", 6'b000000, 6'b100010);
        chk_all("sub.exec", 22'h004054, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("sub.wb", 22'h002800, 4'd4, 1'b0, 1'b0, 1'b1);
        tick();
        fetch_decode("xor", 6'b000000, 6'b100110);
        ovfl = 1'b1;
        chk_all("xor.exec", 22'h004059, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        ovfl = 1'b0;
        chk_all("xor.wb", 22'h002800, 4'd4, 1'b0, 1'b0, 1'b1);
        tick();

        // shifts use imm on Y
        fetch_decode("sll", 6'b000000, 6'b000000);
        chk_all("sll.exec", 22'h00406A, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        fetch_decode("sra", 6'b000000, 6'b000011);
        chk_all("sra.exec", 22'h00406E, 4'd2, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // I-type
        fetch_decode("ori", 6'b001101, 6'b010101);
        chk_all("ori.exec", 22'h004065, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("ori.wb", 22'h002000, 4'd4, 1'b0, 1'b0, 1'b1);
        tick();
        fetch_decode("addiov", 6'b001000, 6'b000000);
        ovfl = 1'b1;
        chk_all("addiov.exec", 22'h004060, 4'd3, 1'b0, 1'b0, 1'b0);
        tick();
        ovfl = 1'b0;
        chk_all("addiov.wb", 22'h000000, 4'd4, 1'b0, 1'b1, 1'b1);
        tick();

        // lw with two wait cycles in MEM_RD
        fetch_decode("lw", 6'b100011, 6'b000000);
        chk_all("lw.addr", 22'h004060, 4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0;
        chk_all("lw.rd0", 22'h028000, 4'd6, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("lw.rd1", 22'h028000, 4'd6, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b1;
        chk_all("lw.rd2", 22'h028000, 4'd6, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("lw.wb", 22'h002200, 4'd8, 1'b0, 1'b0, 1'b1);
        tick();

        // sw with one wait cycle
        fetch_decode("sw", 6'b101011, 6'b000000);
        chk_all("sw.addr", 22'h004060, 4'd5, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b0;
        chk_all("sw.wr0", 22'h018000, 4'd7, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b1;
        chk_all("sw.wr1", 22'h018000, 4'd7, 1'b0, 1'b0, 1'b1);
        tick();

        // beq / bne, both alu_zero values within the BRANCH cycle
        fetch_decode("beq", 6'b000100, 6'b000000);
        alu_zero = 1'b1;
        chk_all("beq.z1", 22'h280054, 4'd9, 1'b0, 1'b0, 1'b1);
        alu_zero = 1'b0;
        chk_all("beq.z0", 22'h080054, 4'd9, 1'b0, 1'b0, 1'b1);
        tick();
        fetch_decode("bne", 6'b000101, 6'b000000);
        alu_zero = 1'b1;
        chk_all("bne.z1", 22'h080054, 4'd9, 1'b0, 1'b0, 1'b1);
        alu_zero = 1'b0;
        chk_all("bne.z0", 22'h280054, 4'd9, 1'b0, 1'b0, 1'b1);
        tick();

        // jumps
        fetch_decode("jal", 6'b000011, 6'b000000);
        chk_all("jal.jump", 22'h303400, 4'd10, 1'b0, 1'b0, 1'b1);
        tick();
        fetch_decode("j", 6'b000010, 6'b000000);
        chk_all("j.jump", 22'h300000, 4'd10, 1'b0, 1'b0, 1'b1);
        tick();
        fetch_decode("jr", 6'b000000, 6'b001000);
        chk_all("jr.jump", 22'h380000, 4'd11, 1'b0, 1'b0, 1'b1);
        tick();

        // illegal opcode and illegal R-type function
        mem_ready = 1'b1;
        tick();
        op = 6'b111111;
        chk_all("ill.decode", 22'h004030, 4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("ill.back", 22'h260000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        op = 6'b000000;
        fn = 6'b111111;
        chk_all("illfn.decode", 22'h004030, 4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("illfn.back", 22'h260000, 4'd0, 1'b0, 1'b0, 1'b0);

        // reset asserted mid-MEM_RD, released with mem_ready=1
        fetch_decode("lwrst", 6'b100011, 6'b000000);
        tick();
        mem_ready = 1'b0;
        chk_all("lwrst.rd", 22'h028000, 4'd6, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk_all("lwrst.inreset", 22'h000000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        mem_ready = 1'b1;
        chk_all("lwrst.inreset2", 22'h000000, 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        chk_all("lwrst.release", 22'h260000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("lwrst.decode", 22'h004030, 4'd1, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multicycle control sequencer that produces the 22-bit control word consumed by the Stage-3 ALU datapath (`ctrl_in`), together with PC, memory, and register-file strobes. It decodes `op`/`fn` from the instruction register and walks a fetch/decode/execute/memory/writeback FSM. It uses `alu_zero`/`ovfl` fed back from the ALU and a `mem_ready` handshake from memory.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- op  in  6  opcode from instruction register, valid from DECODE on
- fn  in  6  function field, valid from DECODE on
- alu_zero  in  1  ALU zero flag, combinational from the current cycle
- ovfl  in  1  ALU signed overflow, combinational from the current cycle
- mem_ready  in  1  memory completes the requested read/write this cycle
- ctrl_out  out  22  control word, bit fields listed under Operation
- state_dbg  out  4  current state encoding
- illegal  out  1  unknown op/fn in DECODE
- ovfl_exc  out  1  writeback suppressed due to overflow
- instr_done  out  1  last cycle of an instruction

## Operation
- ctrl_out fields:
  - [21] PCWRITE
  - [20:19] PCSRC: 00 live ALU z_out, 01 Z reg, 10 jump target, 11 X reg
  - [18] INSTWRITE; [17] MEMREAD; [16] MEMWRITE
  - [15] IORD: 0 PC, 1 Z
  - [14] ZWRITE; [13] REGWRITE
  - [12:11] REGDST: 00 rt, 01 rd, 10 $31
  - [10:9] REGINSRC: 00 Z, 01 mem data, 10 PC
  - [8] reserved, 0
  - [7:6] ALUSRCX: 00 PC, 01 X, 10 Z
  - [5:4] ALUSRCY: 00 const 4, 01 Y, 10 imm, 11 imm<<2
  - [3:2] LOGICFN: 00 AND, 01 OR, 10 XOR, 11 NOR; shift: 00 ROT, 01 SRL, 10 SLL, 11 SRA
  - [1:0] FNTYPE: 00 arith, 01 logic, 10 shift
- ADDSUB is bit 2: add = LOGICFN 00, sub = LOGICFN 01 with FNTYPE 00.
- States (state_dbg): FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, WB_ALU 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7, WB_MEM 8, BRANCH 9, JUMP 10, JUMP_REG 11.
- FETCH: MEMREAD, X=PC, Y=4, add. Hold until mem_ready. In the mem_ready cycle also assert PCWRITE (PCSRC 00) and INSTWRITE, then go to DECODE.
- DECODE: X=PC, Y=imm<<2, add, ZWRITE (branch target into Z). Latch op/fn. Dispatch:
  - op 000000 with fn add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111, sll 000000, srl 000010, sra 000011 → EXEC_R.
  - op 000000 with fn 001000 (jr) → JUMP_REG.
  - addi 001000, andi 001100, ori 001101, xori 001110 → EXEC_I.
  - lw 100011, sw 101011 → MEM_ADDR.
  - beq 000100, bne 000101 → BRANCH.
  - j 000010, jal 000011 → JUMP.
  - Anything else: illegal=1, → FETCH.
- EXEC_R: X=X reg, ZWRITE.
  - Arith/logic ops: Y=Y reg.
  - Shifts: Y=imm (shamt on imm bus; rt steered to X by register read).
  - Register ovfl for add/sub. Next WB_ALU.
- EXEC_I: X=X reg, Y=imm, ZWRITE. Register ovfl for addi. Next WB_ALU.
- WB_ALU: REGWRITE, REGINSRC 00, REGDST 01 (R-type) / 00 (I-type). If the overflow flag is set, REGWRITE=0 and ovfl_exc=1. → FETCH.
- MEM_ADDR: X=X reg, Y=imm, add, ZWRITE. → MEM_RD (lw) / MEM_WR (sw).
- MEM_RD: MEMREAD, IORD=1. Hold until mem_ready, then → WB_MEM.
- MEM_WR: MEMWRITE, IORD=1. Hold until mem_ready, then → FETCH.
- WB_MEM: REGWRITE, REGDST 00, REGINSRC 01. → FETCH.
- BRANCH: X=X reg, Y=Y reg, sub, PCSRC 01. PCWRITE = alu_zero (beq) / !alu_zero (bne). → FETCH.
- JUMP: PCWRITE, PCSRC 10. For jal also REGWRITE, REGDST 10, REGINSRC 10. → FETCH.
- JUMP_REG: PCWRITE, PCSRC 11. → FETCH.
- instr_done=1 in: WB_ALU, WB_MEM, MEM_WR when mem_ready=1, BRANCH, JUMP, JUMP_REG.
- Every field not listed for a state is 0.

## Timing
- Reset low (any state, mid-instruction included):
  - state → FETCH immediately.
  - Latched op/fn and overflow flag cleared.
  - ctrl_out forced to 0; illegal, ovfl_exc, instr_done = 0.
- First cycle after reset release: ctrl_out = 22'h020000 (mem_ready=0) or 22'h260000 (mem_ready=1).
- ctrl_out, illegal, ovfl_exc and instr_done decode combinationally from state, latched fields, mem_ready and alu_zero. State and flags are registered.
- Latency with mem_ready tied 1: R/I ALU 4 cycles, lw 5, sw 4, beq/bne 3, j/jal/jr 3, illegal 2.
- Each mem_ready-low cycle in FETCH/MEM_RD/MEM_WR adds one cycle. ctrl_out is held stable while waiting.
- The overflow flag is written only in EXEC_R/EXEC_I and cleared on entry to FETCH.

## Test plan
- Reset low mid-MEM_RD, then release with mem_ready=1 → ctrl_out 0 during reset, then 22'h260000, state_dbg 0.
- add (op 0, fn 100000), mem_ready=1:
  - DECODE 22'h004030, EXEC_R 22'h004050, WB_ALU 22'h002800 with instr_done=1.
  - Repeat with ovfl=1 in EXEC_R → WB_ALU 22'h000800, ovfl_exc=1.
- lw with mem_ready low 2 cycles in MEM_RD:
  - MEM_ADDR 22'h004060.
  - MEM_RD 22'h028000 held 3 cycles.
  - WB_MEM 22'h002200; total 7 cycles.
- beq: alu_zero=1 → BRANCH 22'h280054; alu_zero=0 → 22'h080054; bne inverts both.
- jal → JUMP 22'h303400, then FETCH.
- op 111111 → illegal=1 in DECODE, next state FETCH, no REGWRITE/MEMWRITE/PCWRITE asserted.
